axi_wr_burst_master: RTL

Write-path engine downstream of the write FIFO group. Pops one command and its data beats through the FIFO req/ack pop handshakes. Drives AXI4 AW, W and B channels for one burst, then pushes the B response into the response FIFO. One transaction is outstanding at a time.

---
 rtl/axi_wr_burst_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_wr_burst_master.sv
// Single-outstanding AXI4 write burst engine: pops a command and its beats from the
// write FIFOs, runs AW/W/B for one burst, then pushes the B response to the response FIFO.
module axi_wr_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int CMD_W   = ID_W + ADDR_W + 13,
  parameter int DWORD_W = DATA_W + DATA_W / 8,
  parameter int RESP_W  = ID_W + 2
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                cmd_pop_req,
  input  logic [CMD_W-1:0]    cmd_pop_struct,
  input  logic                cmd_pop_ack,
  input  logic                cmd_fifo_empty,
  output logic                data_pop_req,
  input  logic [DWORD_W-1:0]  data_pop_struct,
  input  logic                data_pop_ack,
  output logic                resp_push_req,
  output logic [RESP_W-1:0]   resp_push_struct,
  input  logic                resp_push_ack,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                busy,
  output logic                id_mismatch
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_POP, S_AW, S_DAT_POP, S_W, S_B, S_RESP_PUSH
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_pop_req_q, cmd_pop_req_d;
  logic                data_pop_req_q, data_pop_req_d;
  logic                resp_push_req_q, resp_push_req_d;
  logic [RESP_W-1:0]   resp_push_struct_q, resp_push_struct_d;
  logic [ID_W-1:0]     awid_q, awid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [1:0]          awburst_q, awburst_d;
  logic                awvalid_q, awvalid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                wlast_q, wlast_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                busy_q, busy_d;
  logic                id_mismatch_q, id_mismatch_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;

  always_comb begin
    state_d            = state_q;
    cmd_pop_req_d      = cmd_pop_req_q;
    data_pop_req_d     = data_pop_req_q;
    resp_push_req_d    = resp_push_req_q;
    resp_push_struct_d = resp_push_struct_q;
    awid_d             = awid_q;
    awaddr_d           = awaddr_q;
    awlen_d            = awlen_q;
    awsize_d           = awsize_q;
    awburst_d          = awburst_q;
    awvalid_d          = awvalid_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    wlast_d            = wlast_q;
    wvalid_d           = wvalid_q;
    bready_d           = bready_q;
    id_mismatch_d      = id_mismatch_q;
    beat_cnt_d         = beat_cnt_q;

    // Every FIFO request is a fresh rising edge: it rises only once the ack is seen low.
    case (state_q)
      S_IDLE: begin
        if (!cmd_fifo_empty && !cmd_pop_ack) begin
          cmd_pop_req_d = 1'b1;
          state_d       = S_CMD_POP;
        end
      end
      S_CMD_POP: begin
        if (cmd_pop_ack) begin
          cmd_pop_req_d = 1'b0;
          {awid_d, awaddr_d, awlen_d, awsize_d, awburst_d} = cmd_pop_struct;
          beat_cnt_d    = 8'd0;
          awvalid_d     = 1'b1;
          state_d       = S_AW;
        end
      end
      S_AW: begin
        if (m_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_DAT_POP;
        end
      end
      S_DAT_POP: begin
        if (!data_pop_req_q) begin
          if (!data_pop_ack) data_pop_req_d = 1'b1;
        end else if (data_pop_ack) begin
          data_pop_req_d     = 1'b0;
          {wstrb_d, wdata_d} = data_pop_struct;
          wlast_d            = (beat_cnt_q == awlen_q);
          wvalid_d           = 1'b1;
          state_d            = S_W;
        end
      end
      S_W: begin
        if (m_wready) begin
          wvalid_d = 1'b0;
          if (wlast_q) begin
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            state_d    = S_DAT_POP;
          end
        end
      end
      S_B: begin
        if (m_bvalid) begin
          bready_d           = 1'b0;
          resp_push_struct_d = {m_bid, m_bresp};
          if (m_bid != awid_q) id_mismatch_d = 1'b1;
          state_d            = S_RESP_PUSH;
        end
      end
      S_RESP_PUSH: begin
        if (!resp_push_req_q) begin
          if (!resp_push_ack) resp_push_req_d = 1'b1;
        end else if (resp_push_ack) begin
          resp_push_req_d = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q            <= S_IDLE;
      cmd_pop_req_q      <= 1'b0;
      data_pop_req_q     <= 1'b0;
      resp_push_req_q    <= 1'b0;
      resp_push_struct_q <= '0;
      awid_q             <= '0;
      awaddr_q           <= '0;
      awlen_q            <= '0;
      awsize_q           <= '0;
      awburst_q          <= '0;
      awvalid_q          <= 1'b0;
      wdata_q            <= '0;
      wstrb_q            <= '0;
      wlast_q            <= 1'b0;
      wvalid_q           <= 1'b0;
      bready_q           <= 1'b0;
      busy_q             <= 1'b0;
      id_mismatch_q      <= 1'b0;
      beat_cnt_q         <= '0;
    end else begin
      state_q            <= state_d;
      cmd_pop_req_q      <= cmd_pop_req_d;
      data_pop_req_q     <= data_pop_req_d;
      resp_push_req_q    <= resp_push_req_d;
      resp_push_struct_q <= resp_push_struct_d;
      awid_q             <= awid_d;
      awaddr_q           <= awaddr_d;
      awlen_q            <= awlen_d;
      awsize_q           <= awsize_d;
      awburst_q          <= awburst_d;
      awvalid_q          <= awvalid_d;
      wdata_q            <= wdata_d;
      wstrb_q            <= wstrb_d;
      wlast_q            <= wlast_d;
      wvalid_q           <= wvalid_d;
      bready_q           <= bready_d;
      busy_q             <= busy_d;
      id_mismatch_q      <= id_mismatch_d;
      beat_cnt_q         <= beat_cnt_d;
    end
  end

  assign cmd_pop_req      = cmd_pop_req_q;
  assign data_pop_req     = data_pop_req_q;
  assign resp_push_req    = resp_push_req_q;
  assign resp_push_struct = resp_push_struct_q;
  assign m_awid           = awid_q;
  assign m_awaddr         = awaddr_q;
  assign m_awlen          = awlen_q;
  assign m_awsize         = awsize_q;
  assign m_awburst        = awburst_q;
  assign m_awvalid        = awvalid_q;
  assign m_wdata          = wdata_q;
  assign m_wstrb          = wstrb_q;
  assign m_wlast          = wlast_q;
  assign m_wvalid         = wvalid_q;
  assign m_bready         = bready_q;
  assign busy             = busy_q;
  assign id_mismatch      = id_mismatch_q;

endmodule
